popcount_threshold_packer: RTL and testbench



---
 rtl/bnn_pkg.sv | 25 ++
 rtl/bit_packer.sv | 89 ++++++++
 rtl/popcount_threshold_packer.sv | 80 ++++++++
 tb/tb_popcount_threshold_packer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized-layer datapath: default sizes, derived
// widths and the per-neuron threshold record used by the threshold loader.
package bnn_pkg;

    localparam int POP_W_DEF  = 10;
    localparam int CHUNKS_DEF = 4;
    localparam int PACK_DEF   = 16;

    // Accumulator must hold CHUNKS * (2**POP_W - 1) without overflow.
    function automatic int acc_width(input int pop_w, input int chunks);
        return pop_w + $clog2(chunks + 1);
    endfunction

    function automatic int idx_width(input int pack);
        return $clog2(pack + 1);
    endfunction

    localparam int ACC_W_DEF = acc_width(POP_W_DEF, CHUNKS_DEF);

    typedef struct packed {
        logic [ACC_W_DEF-1:0] thr;
        logic                 flip;
    } thr_rec_t;

endpackage

// File: rtl/bit_packer.sv
// Packs one activation bit per completed neuron LSB-first into PACK-bit words
// and owns the output register, its valid/ready handshake and flush handling.
module bit_packer #(
    parameter int PACK = 16,
    localparam int IDX_W = $clog2(PACK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_val,
    input  logic             flush,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PACK-1:0]  out_bits,
    output logic [IDX_W-1:0] out_len
);

    localparam int SEL_W = (PACK > 1) ? $clog2(PACK) : 1;

    logic [PACK-1:0]  pack_reg_q, pack_reg_d, pack_ins;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d, idx_next;
    logic             out_valid_q, out_valid_d;
    logic [PACK-1:0]  out_bits_q, out_bits_d;
    logic [IDX_W-1:0] out_len_q, out_len_d;
    logic             flush_acc;

    // Single-word stall: nothing new may land while a word is blocked.
    assign in_ready  = !(out_valid_q && !out_ready);
    assign flush_acc = flush && in_ready;

    always_comb begin
        pack_ins = pack_reg_q;
        idx_next = bit_idx_q;
        if (bit_valid) begin
            pack_ins[bit_idx_q[SEL_W-1:0]] = bit_val;
            idx_next = bit_idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        pack_reg_d  = pack_reg_q;
        bit_idx_d   = bit_idx_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_len_d   = out_len_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // A completing word wins over flush; the flush then sees an empty word.
        if (bit_valid && (bit_idx_q == IDX_W'(PACK - 1))) begin
            out_bits_d  = pack_ins;
            out_len_d   = IDX_W'(PACK);
            out_valid_d = 1'b1;
            pack_reg_d  = '0;
            bit_idx_d   = '0;
        end else if (flush_acc && (idx_next != '0)) begin
            out_bits_d  = pack_ins;
            out_len_d   = idx_next;
            out_valid_d = 1'b1;
            pack_reg_d  = '0;
            bit_idx_d   = '0;
        end else begin
            pack_reg_d = pack_ins;
            bit_idx_d  = idx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_reg_q  <= '0;
            bit_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_len_q   <= '0;
        end else begin
            pack_reg_q  <= pack_reg_d;
            bit_idx_q   <= bit_idx_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_len_q   <= out_len_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign out_len   = out_len_q;

endmodule

// File: rtl/popcount_threshold_packer.sv
// Accumulates CHUNKS partial popcounts per neuron, thresholds the sum (with
// optional sign flip) and hands each activation bit to the word packer.
module popcount_threshold_packer
    import bnn_pkg::*;
#(
    parameter int POP_W  = POP_W_DEF,
    parameter int CHUNKS = CHUNKS_DEF,
    parameter int PACK   = PACK_DEF,
    localparam int ACC_W = acc_width(POP_W, CHUNKS),
    localparam int IDX_W = idx_width(PACK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POP_W-1:0] in_pop,
    input  logic [ACC_W-1:0] in_thr,
    input  logic             in_flip,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PACK-1:0]  out_bits,
    output logic [IDX_W-1:0] out_len
);

    localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] chunk_cnt_q, chunk_cnt_d;
    logic [ACC_W-1:0] sum;
    logic             accept;
    logic             last_chunk;
    logic             act_bit;

    assign accept     = in_valid && in_ready;
    assign last_chunk = (chunk_cnt_q == CNT_W'(CHUNKS - 1));
    assign sum        = acc_q + ACC_W'(in_pop);
    // Folded batch-norm: a negative gamma reverses the comparison direction.
    assign act_bit    = (sum >= in_thr) ^ in_flip;

    always_comb begin
        acc_d       = acc_q;
        chunk_cnt_d = chunk_cnt_q;
        if (accept) begin
            if (last_chunk) begin
                acc_d       = '0;
                chunk_cnt_d = '0;
            end else begin
                acc_d       = sum;
                chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            chunk_cnt_q <= '0;
        end else begin
            acc_q       <= acc_d;
            chunk_cnt_q <= chunk_cnt_d;
        end
    end

    bit_packer #(
        .PACK(PACK)
    ) u_bit_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (accept && last_chunk),
        .bit_val   (act_bit),
        .flush     (flush),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_len   (out_len)
    );

endmodule

// File: tb/tb_popcount_threshold_packer.sv
// Self-checking bench for popcount_threshold_packer with a word scoreboard.
module tb_popcount_threshold_packer;

    localparam int POP_W  = 10;
    localparam int CHUNKS = 4;
    localparam int PACK   = 16;
    localparam int ACC_W  = 13;
    localparam int IDX_W  = 5;

    typedef struct {
        logic [PACK-1:0]  bits;
        logic [IDX_W-1:0] len;
    } word_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [POP_W-1:0] in_pop;
    logic [ACC_W-1:0] in_thr;
    logic             in_flip;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [PACK-1:0]  out_bits;
    logic [IDX_W-1:0] out_len;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int words_seen = 0;
    int ov_cycles = 0;
    logic [PACK-1:0]  last_bits = '0;
    logic [IDX_W-1:0] last_len = '0;
    word_t sb[$];

    int m_acc = 0;
    int m_cnt = 0;
    int m_idx = 0;
    logic [PACK-1:0] m_bits = '0;

    always #5 clk = ~clk;

    popcount_threshold_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pop    (in_pop),
        .in_thr    (in_thr),
        .in_flip   (in_flip),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_len   (out_len)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock step: sample at the falling edge, pop/compare any handshaked word.
    task automatic cycle(output logic rdy);
        word_t e;
        @(negedge clk);
        rdy = in_ready;
        if (out_valid) ov_cycles++;
        if (out_valid && out_ready) begin
            words_seen++;
            last_bits = out_bits;
            last_len  = out_len;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got bits=%h len=%0d, none expected", out_bits, out_len);
            end else begin
                e = sb.pop_front();
                if (out_bits !== e.bits || out_len !== e.len) begin
                    errors++;
                    $display("FAIL word: got bits=%h len=%0d, expected bits=%h len=%0d",
                             out_bits, out_len, e.bits, e.len);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic rdy;
        for (int i = 0; i < n; i++) cycle(rdy);
    endtask

    task automatic model_accept(input int pop, input int thr, input bit flip);
        bit b;
        m_acc += pop;
        if (m_cnt == CHUNKS - 1) begin
            b = (m_acc >= thr) ^ flip;
            m_bits[m_idx] = b;
            m_idx++;
            m_acc = 0;
            m_cnt = 0;
            if (m_idx == PACK) begin
                sb.push_back('{bits: m_bits, len: IDX_W'(PACK)});
                m_bits = '0;
                m_idx  = 0;
            end
        end else begin
            m_cnt++;
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_idx = 0; m_bits = '0;
        sb.delete();
    endtask

    task automatic drive_beat(input int pop, input int thr, input bit flip);
        logic rdy;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_pop   = pop[POP_W-1:0];
        in_thr   = thr[ACC_W-1:0];
        in_flip  = flip;
        do begin
            cycle(rdy);
            n++;
        end while (!rdy && n < 1000);
        in_valid = 1'b0;
        if (rdy) model_accept(pop, thr, flip);
        else begin
            errors++;
            $display("FAIL beat_timeout: in_ready stayed %b, expected 1 within 1000 cycles", rdy);
        end
    endtask

    task automatic send_neuron(input int sum, input int thr, input bit flip);
        int q;
        q = sum / CHUNKS;
        for (int i = 0; i < CHUNKS - 1; i++) drive_beat(q, thr, flip);
        drive_beat(sum - q * (CHUNKS - 1), thr, flip);
    endtask

    task automatic send_random_neuron();
        int thr;
        bit flip;
        thr  = $urandom_range(0, 600);
        flip = 1'($urandom_range(0, 1));
        for (int i = 0; i < CHUNKS; i++) drive_beat($urandom_range(0, 144), thr, flip);
    endtask

    task automatic do_flush();
        logic rdy;
        int n;
        n = 0;
        flush = 1'b1;
        do begin
            cycle(rdy);
            n++;
        end while (!rdy && n < 1000);
        flush = 1'b0;
        if (!rdy) begin
            errors++;
            $display("FAIL flush_timeout: in_ready stayed %b, expected 1", rdy);
        end else if (m_idx > 0) begin
            sb.push_back('{bits: m_bits, len: IDX_W'(m_idx)});
            m_bits = '0;
            m_idx  = 0;
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d words outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_pop = '0; in_thr = '0; in_flip = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        #23;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++;
        if (out_bits !== '0) begin errors++; $display("FAIL reset_out_bits: got %h, expected 0000", out_bits); end
        checks++;
        if (out_len !== '0) begin errors++; $display("FAIL reset_out_len: got %0d, expected 0", out_len); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_all_ones();
        for (int n = 0; n < PACK; n++) begin
            drive_beat(100, 288, 1'b0);
            drive_beat(150, 288, 1'b0);
            drive_beat(200, 288, 1'b0);
            drive_beat(126, 288, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL all_ones_latency: out_valid=%b after 64th beat, expected 1", out_valid); end
        idle(2);
        checks++;
        if (last_bits !== 16'hFFFF || last_len !== 5'd16) begin
            errors++;
            $display("FAIL all_ones_word: got %h/%0d, expected ffff/16", last_bits, last_len);
        end
        check_drained("all_ones");
    endtask

    task automatic test_alternating();
        for (int n = 0; n < PACK / 2; n++) begin
            send_neuron(576, 577, 1'b0);
            send_neuron(0, 0, 1'b1);
        end
        idle(2);
        checks++;
        if (last_bits !== 16'h0000) begin errors++; $display("FAIL alt_flip_word: got %h, expected 0000", last_bits); end
        for (int n = 0; n < PACK / 2; n++) begin
            send_neuron(576, 577, 1'b0);
            send_neuron(0, 0, 1'b0);
        end
        idle(2);
        checks++;
        if (last_bits !== 16'hAAAA) begin errors++; $display("FAIL alt_noflip_word: got %h, expected aaaa", last_bits); end
        check_drained("alternating");
    endtask

    task automatic test_backpressure();
        logic rdy;
        logic [PACK-1:0] saved;
        out_ready = 1'b0;
        for (int n = 0; n < PACK; n++) send_random_neuron();
        saved = out_bits;
        in_valid = 1'b1; in_pop = 10'd50; in_thr = 13'd100; in_flip = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(rdy);
            checks++;
            if (rdy !== 1'b0 || out_valid !== 1'b1 || out_bits !== saved) begin
                errors++;
                $display("FAIL stall_hold: in_ready=%b out_valid=%b bits=%h, expected 0/1/%h",
                         rdy, out_valid, out_bits, saved);
            end
        end
        out_ready = 1'b1;
        cycle(rdy);
        in_valid = 1'b0;
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL stall_release: in_ready=%b, expected 1", rdy); end
        else model_accept(50, 100, 1'b0);
        for (int i = 0; i < CHUNKS - 1; i++) drive_beat(60, 100, 1'b0);
        for (int n = 1; n < PACK; n++) send_random_neuron();
        idle(2);
        check_drained("backpressure");
    endtask

    task automatic test_flush();
        for (int n = 0; n < 5; n++) send_neuron(576, 288, 1'b0);
        do_flush();
        idle(2);
        checks++;
        if (last_bits !== 16'h001F || last_len !== 5'd5) begin
            errors++;
            $display("FAIL flush_word: got %h/%0d, expected 001f/5", last_bits, last_len);
        end
        do_flush();
        for (int i = 0; i < 4; i++) begin
            idle(1);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: out_valid=%b, expected 0", out_valid); end
        end
        check_drained("flush");
    endtask

    task automatic test_back_to_back();
        int c0, w0, v0;
        c0 = cyc; w0 = words_seen; v0 = ov_cycles;
        for (int n = 0; n < 3 * PACK; n++) send_random_neuron();
        checks++;
        if (cyc - c0 !== 3 * PACK * CHUNKS) begin
            errors++;
            $display("FAIL b2b_throughput: %0d cycles, expected %0d", cyc - c0, 3 * PACK * CHUNKS);
        end
        idle(2);
        checks++;
        if (words_seen - w0 !== 3 || ov_cycles - v0 !== 3) begin
            errors++;
            $display("FAIL b2b_words: words=%0d valid_cycles=%0d, expected 3/3", words_seen - w0, ov_cycles - v0);
        end
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 7; n++) send_neuron(576, 288, 1'b0);
        drive_beat(100, 288, 1'b0);
        drive_beat(100, 288, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_bits !== '0 || out_len !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b bits=%h len=%0d, expected 0/0000/0", out_valid, out_bits, out_len);
        end
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int n = 0; n < PACK; n++) begin
            if (n % 3 == 0) send_neuron(400, 300, 1'b0);
            else            send_neuron(200, 300, 1'b0);
        end
        idle(2);
        checks++;
        if (last_bits !== 16'h9249 || last_len !== 5'd16) begin
            errors++;
            $display("FAIL post_reset_word: got %h/%0d, expected 9249/16", last_bits, last_len);
        end
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_alternating();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
